imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 146 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with valid/ready handshake
// Optional skid-buffer storage selected by macro IMM_SKID_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      din,
    input  logic [2:0]       sext_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             bad_op
);

    logic [31:7]     inst;
    logic [XLEN-1:0] imm;
    logic            acc;

    logic             o_valid_q, o_valid_d;
    logic [XLEN-1:0]  o_ext_q, o_ext_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;
    logic             bad_op_q, bad_op_d;

    assign inst = din;

    always_comb begin
        imm = '0;
        case (sext_op)
            3'd1: imm = XLEN'($signed(inst[31:20]));
            3'd2: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            3'd3: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            3'd4: imm = XLEN'($signed({inst[31:12], 12'h000}));
            3'd5: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            3'd6: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            3'd7: imm = XLEN'(inst[19:15]);
            default: imm = '0;
        endcase
    end

    assign acc = in_valid && in_ready;

`ifdef IMM_SKID_EN
    logic             s_valid_q, s_valid_d;
    logic [XLEN-1:0]  s_ext_q, s_ext_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;
    logic             rdy_q, rdy_d;

    // in_ready comes from a flop, so out_ready never reaches it combinationally
    assign in_ready = rst_n && !flush && rdy_q;

    always_comb begin
        o_valid_d = o_valid_q;
        o_ext_d   = o_ext_q;
        o_tag_d   = o_tag_q;
        s_valid_d = s_valid_q;
        s_ext_d   = s_ext_q;
        s_tag_d   = s_tag_q;
        bad_op_d  = bad_op_q | (acc && (sext_op == 3'd0));
        if (flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid_q || out_ready) begin
            if (s_valid_q) begin
                o_valid_d = 1'b1;
                o_ext_d   = s_ext_q;
                o_tag_d   = s_tag_q;
                s_valid_d = acc;
                if (acc) begin
                    s_ext_d = imm;
                    s_tag_d = in_tag;
                end
            end else begin
                o_valid_d = acc;
                if (acc) begin
                    o_ext_d = imm;
                    o_tag_d = in_tag;
                end
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_ext_d   = imm;
            s_tag_d   = in_tag;
        end
        rdy_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            s_ext_q   <= '0;
            s_tag_q   <= '0;
            rdy_q     <= 1'b1;
        end else begin
            s_valid_q <= s_valid_d;
            s_ext_q   <= s_ext_d;
            s_tag_q   <= s_tag_d;
            rdy_q     <= rdy_d;
        end
    end
`else
    assign in_ready = rst_n && !flush && (!o_valid_q || out_ready);

    always_comb begin
        o_valid_d = o_valid_q;
        o_ext_d   = o_ext_q;
        o_tag_d   = o_tag_q;
        bad_op_d  = bad_op_q | (acc && (sext_op == 3'd0));
        if (flush) begin
            o_valid_d = 1'b0;
        end else if (!o_valid_q || out_ready) begin
            o_valid_d = acc;
            if (acc) begin
                o_ext_d = imm;
                o_tag_d = in_tag;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_ext_q   <= '0;
            o_tag_q   <= '0;
            bad_op_q  <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_ext_q   <= o_ext_d;
            o_tag_q   <= o_tag_d;
            bad_op_q  <= bad_op_d;
        end
    end

    assign out_valid = o_valid_q;
    assign ext       = o_ext_q;
    assign out_tag   = o_tag_q;
    assign bad_op    = bad_op_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             flush = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [24:0]      din = '0;
    logic [2:0]       sext_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 0;
    logic [XLEN-1:0]  ext;
    logic [TAG_W-1:0] out_tag;
    logic             bad_op;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .sext_op(sext_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ext(ext), .out_tag(out_tag), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: immediates from field arithmetic on the full 32-bit instruction word
    function automatic logic [XLEN-1:0] model_imm(input logic [31:0] i, input logic [2:0] op);
        logic [31:0] m;
        logic [31:0] r;
        logic [63:0] v;
        m = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (op)
            3'd1: r = (m << 12) | (i >> 20);
            3'd2: r = (m << 12) | ((i >> 25) << 5) | ((i >> 7) & 31);
            3'd3: r = (m << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1);
            3'd4: r = i & 32'hFFFF_F000;
            3'd5: r = (m << 20) | (((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1);
            3'd6: r = (i >> 20) & ((XLEN == 64) ? 63 : 31);
            3'd7: r = (i >> 15) & 31;
            default: r = 0;
        endcase
        v = {{32{r[31]}}, r};
        return v[XLEN-1:0];
    endfunction

    typedef struct { logic [XLEN-1:0] e; logic [TAG_W-1:0] t; } ent_t;
    ent_t             q[$];
    logic [TAG_W-1:0] drained[$];
    logic             bad_m = 0;
    logic             rst_seen = 0;
    logic             started = 0;
    logic             stall_prev = 0;
    logic [XLEN-1:0]  ext_prev;
    logic [TAG_W-1:0] tag_prev;

    always @(negedge clk) begin
        logic exp_ir;
        ent_t n;
        if (started) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("ext", 64'(ext), 64'(q[0].e));
                chk("out_tag", 64'(out_tag), 64'(q[0].t));
            end
`ifdef IMM_SKID_EN
            exp_ir = rst_n && !flush && (q.size() < 2);
`else
            exp_ir = rst_n && !flush && (!out_valid || out_ready);
`endif
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            chk("bad_op", 64'(bad_op), 64'(bad_m));
            if (rst_seen) begin
                chk("reset_ext", 64'(ext), 64'h0);
                chk("reset_tag", 64'(out_tag), 64'h0);
            end
            if (stall_prev) begin
                chk("stall_ext", 64'(ext), 64'(ext_prev));
                chk("stall_tag", 64'(out_tag), 64'(tag_prev));
            end
        end
        stall_prev = rst_n && !flush && out_valid && !out_ready;
        ext_prev   = ext;
        tag_prev   = out_tag;
        if (!rst_n) begin
            q.delete();
            bad_m    = 0;
            rst_seen = 1;
        end else begin
            rst_seen = 0;
            if (flush) q.delete();
            else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    drained.push_back(q[0].t);
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    n.e = model_imm({din, 7'h0}, sext_op);
                    n.t = in_tag;
                    q.push_back(n);
                    if (sext_op == 3'd0) bad_m = 1;
                end
            end
        end
        started = 1;
    end

    int mode = 0;
    always begin
        @(posedge clk);
        #2;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom % 2);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [2:0] op, input logic [TAG_W-1:0] t);
        logic a;
        int   n;
        in_valid = 1;
        din      = i[31:7];
        sext_op  = op;
        in_tag   = t;
        n = 0;
        do begin
            @(negedge clk);
            a = in_ready;
            tick();
            n++;
        end while (!a && n < 200);
        chk("send_accept", 64'(a), 64'h1);
        in_valid = 0;
    endtask

    task automatic lit(input string name, input logic [31:0] i, input logic [2:0] op, input logic [63:0] e);
        logic [63:0] ev;
        ev = e;
        send(i, op, 5'h3);
        @(negedge clk);
        chk(name, 64'(ext), 64'(ev[XLEN-1:0]));
        chk({name, "_model"}, 64'(model_imm(i, op)), 64'(ev[XLEN-1:0]));
    endtask

    initial begin
        in_valid = 1;
        mode = 0;
        repeat (3) tick();
        in_valid = 0;
        rst_n = 1;
        tick();

        lit("I",     32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        lit("B",     32'hFE00_0EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        lit("J",     32'h8000_006F, 3'd5, 64'hFFFF_FFFF_FFF0_0000);
        lit("SHIFT", 32'h03F0_1013, 3'd6, (XLEN == 64) ? 64'h3F : 64'h1F);
        lit("U",     32'h8000_00B7, 3'd4, 64'hFFFF_FFFF_8000_0000);
        lit("S",     32'hFE11_2E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
        lit("Z",     32'h000F_D073, 3'd7, 64'h1F);
        tick();

        drained.delete();
        mode = 1;
        for (int k = 1; k <= 8; k++) send($urandom, 3'($urandom_range(1, 7)), TAG_W'(k));
        begin
            int n;
            n = 0;
            while (drained.size() < 8 && n < 300) begin tick(); n++; end
        end
        chk("bp_count", 64'(drained.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            if (k < drained.size()) chk("bp_order", 64'(drained[k]), 64'(k + 1));
        mode = 0;
        tick();

        mode = 2;
        tick();
        send(32'h1234_5013, 3'd1, 5'h1A);
        tick(); tick();
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'h0);
        mode = 0;
        drained.delete();
        repeat (4) tick();
        chk("flush_never_out", 64'(drained.size()), 64'h0);

        mode = 2;
        tick();
        send(32'hFFF0_0093, 3'd1, 5'h15);
        tick();
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ext", 64'(ext), 64'h0);
        chk("rst_tag", 64'(out_tag), 64'h0);
        rst_n = 1;
        mode = 0;
        tick();

        send(32'hFFFF_FFFF, 3'd0, 5'h07);
        @(negedge clk);
        chk("bad_ext", 64'(ext), 64'h0);
        chk("bad_set", 64'(bad_op), 64'h1);
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("bad_after_flush", 64'(bad_op), 64'h1);
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("bad_after_reset", 64'(bad_op), 64'h0);
        tick();

        mode = 1;
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom % 4) != 0;
            din      = 25'($urandom);
            sext_op  = 3'($urandom);
            in_tag   = TAG_W'($urandom);
            flush    = ($urandom % 32) == 0;
            tick();
        end
        in_valid = 0;
        flush = 0;
        mode = 0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
